// File: rtl/dmem_wait_responder_if.sv
// Load/store bus between the core's memory stage (master) and the data-memory responder (slave).
interface dmem_wait_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        busy;
  logic        stall;

  modport master (output req, we, addr, wdata,
                  input  rdata, ready, err, busy, stall);
  modport slave  (input  req, we, addr, wdata,
                  output rdata, ready, err, busy, stall);
endinterface

// File: rtl/dmem_wait_responder.sv
// Fixed-latency word RAM responder for the MIPS memory stage; stalls the pipeline while a request is open.
// state | meaning:  IDLE | waiting for req,  WAIT | counting latency,  DONE | ready pulse, result valid
module dmem_wait_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  dmem_wait_responder_if.slave  bus
);
  localparam int         AW       = $clog2(DEPTH);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] mem_q [DEPTH];

  logic          accept;
  logic          enter_done;
  logic          acc_we;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic          acc_err;
  logic [AW-1:0] acc_idx;

  assign accept = (state_q == ST_IDLE) && bus.req;

  // With LATENCY=1 the access happens on the acceptance edge, before the latches are loaded,
  // so the access fields come straight from the bus while still in IDLE.
  assign acc_we    = (state_q == ST_IDLE) ? bus.we    : we_q;
  assign acc_addr  = (state_q == ST_IDLE) ? bus.addr  : addr_q;
  assign acc_wdata = (state_q == ST_IDLE) ? bus.wdata : wdata_q;
  assign acc_err   = (acc_addr[1:0] != 2'b00) || (acc_addr[31:AW+2] != '0);
  assign acc_idx   = acc_addr[AW+1:2];

  assign enter_done = (accept && (LATENCY == 1)) ||
                      ((state_q == ST_WAIT) && (cnt_q == 4'd1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          cnt_d   = CNT_LOAD;
          state_d = (LATENCY == 1) ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    err_d   = err_q;
    rdata_d = rdata_q;
    if (enter_done) begin
      err_d = acc_err;
      if (!acc_we && !acc_err) rdata_d = mem_q[acc_idx];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      if (accept) begin
        we_q    <= bus.we;
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
      end
    end
  end

  // RAM keeps its contents through reset; the reset gate stops an aborted store from landing.
  always_ff @(posedge clk) begin
    if (reset && enter_done && acc_we && !acc_err) mem_q[acc_idx] <= acc_wdata;
  end

  assign bus.ready = (state_q == ST_DONE);
  assign bus.err   = bus.ready && err_q;
  assign bus.busy  = (state_q != ST_IDLE);
  assign bus.rdata = rdata_q;
  assign bus.stall = bus.req && !bus.ready;
endmodule
